// File: rtl/fifo_arb_pkg.sv
// Purpose: shared types and defaults for the sync_fifo write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

    // Arbiter FSM: waiting to pick a producer, or streaming a locked burst.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 4;
    localparam int ERR_CNT_W     = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Purpose: round-robin search, first set request at or after rr_ptr with wrap-around.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   req     request vector
//   rr_ptr  search start index
//   found   at least one request set
//   idx     winning index (0 when nothing found)
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan from the farthest position back toward rr_ptr so the hit that
        // survives is the nearest one at or after rr_ptr.
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                idx   = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Purpose: generic single-clock FIFO with show-ahead read data.
// Latency: a written word is visible on rdata_o the cycle after the write.
// Backpressure: writes while full and reads while empty are dropped; wr_error_o flags a write into a full FIFO.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wr_en_i, wdata_i    write side
//   rd_en_i, rdata_o    read side (rdata_o shows the head word)
//   full_o, empty_o     occupancy flags
//   wr_error_o          write attempted while full
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             wr_error_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full_o     = (count == (AW+1)'(DEPTH));
    assign empty_o    = (count == '0);
    assign do_wr      = wr_en_i & ~full_o;
    assign do_rd      = rd_en_i & ~empty_o;
    assign wr_error_o = wr_en_i & full_o;
    assign rdata_o    = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem[wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + AW'(1);
            end
            if (do_rd) begin
                rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + AW'(1);
            end
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Purpose: shares one sync_fifo write port among NUM_REQ producers, round-robin with burst lock.
// Latency: 1 idle arbitration cycle per grant, then up to MAX_BURST beats at one per cycle.
// Backpressure: fifo_full_i stalls the granted producer (ready low) without losing the grant.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_valid_i       per-producer beat available
//   req_data_i        producer n data at [n*WIDTH +: WIDTH]
//   req_ready_o       one-hot accept strobe back to the granted producer
//   fifo_wr_en_o      write strobe to sync_fifo
//   fifo_wdata_o      write data to sync_fifo (0 when not writing)
//   fifo_full_i       sync_fifo full flag
//   fifo_wr_error_i   sync_fifo write-error pulse
//   grant_valid_o     burst grant active
//   grant_id_o        granted producer index
//   wr_err_cnt_o      saturating count of write-error cycles
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int CNT_W     = $clog2(MAX_BURST+1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     fifo_wr_en_o,
    output logic [WIDTH-1:0]         fifo_wdata_o,
    input  logic                     fifo_full_i,
    input  logic                     fifo_wr_error_i,
    output logic                     grant_valid_o,
    output logic [ID_W-1:0]          grant_id_o,
    output logic [ERR_CNT_W-1:0]     wr_err_cnt_o
);

    arb_state_t           state_q, state_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [CNT_W-1:0]     beat_q, beat_d;
    logic [ERR_CNT_W-1:0] err_q;

    logic                 pick_found;
    logic [ID_W-1:0]      pick_idx;
    logic                 in_burst;
    logic                 accept;
    logic                 last_beat;
    logic [ID_W-1:0]      grant_inc;
    logic [WIDTH-1:0]     data_arr [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (req_valid_i),
        .rr_ptr (rr_q),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_comb begin
        for (int n = 0; n < NUM_REQ; n++) begin
            data_arr[n] = req_data_i[n*WIDTH +: WIDTH];
        end
    end

    // Outputs are gated by rst_i so the port reads idle during the reset
    // cycle itself, not only after the state register has cleared.
    assign in_burst  = (state_q == ST_BURST) && !rst_i;
    assign accept    = in_burst && req_valid_i[grant_q] && !fifo_full_i;
    assign last_beat = (beat_q == CNT_W'(MAX_BURST-1));
    assign grant_inc = (grant_q == ID_W'(NUM_REQ-1)) ? '0 : grant_q + ID_W'(1);

    assign fifo_wr_en_o  = accept;
    assign fifo_wdata_o  = accept ? data_arr[grant_q] : '0;
    assign req_ready_o   = accept ? (NUM_REQ'(1) << grant_q) : '0;
    assign grant_valid_o = in_burst;
    assign grant_id_o    = rst_i ? '0 : grant_q;
    assign wr_err_cnt_o  = rst_i ? '0 : err_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (accept) begin
                    beat_d = beat_q + CNT_W'(1);
                end
                // A full stall with valid held keeps the grant; only a
                // completed burst or a withdrawn request releases it.
                if ((accept && last_beat) || !req_valid_i[grant_q]) begin
                    state_d = ST_IDLE;
                    rr_d    = grant_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else if (fifo_wr_error_i && (err_q != '1)) begin
            err_q <= err_q + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 16;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_valid_i;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   req_ready_o;
    logic           fifo_wr_en_o;
    logic [W-1:0]   fifo_wdata_o;
    logic           fifo_full_i;
    logic           fifo_wr_error_i;
    logic           grant_valid_o;
    logic [1:0]     grant_id_o;
    logic [15:0]    wr_err_cnt_o;

    logic           rd_en;
    logic [W-1:0]   rdata;
    logic           f_full, f_empty, f_err;
    logic           force_full, force_err;

    always #5 clk_i = ~clk_i;

    assign fifo_full_i     = f_full | force_full;
    assign fifo_wr_error_i = f_err | force_err;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .fifo_wr_en_o    (fifo_wr_en_o),
        .fifo_wdata_o    (fifo_wdata_o),
        .fifo_full_i     (fifo_full_i),
        .fifo_wr_error_i (fifo_wr_error_i),
        .grant_valid_o   (grant_valid_o),
        .grant_id_o      (grant_id_o),
        .wr_err_cnt_o    (wr_err_cnt_o)
    );

    sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (fifo_wr_en_o),
        .wdata_i    (fifo_wdata_o),
        .rd_en_i    (rd_en),
        .rdata_o    (rdata),
        .full_o     (f_full),
        .empty_o    (f_empty),
        .wr_error_o (f_err)
    );

    int total = 0;
    int bad   = 0;

    // Control requested by the test for the next cycle.
    logic         c_rst, c_full, c_err;
    logic [N-1:0] en;

    // Producer beat queues as arrays with head/tail indices.
    logic [W-1:0] pbuf [N][64];
    int           phead [N];
    int           ptail [N];

    // Reference model: who holds the port, beats taken, where the next search starts.
    int           m_owner, m_taken, m_next;
    logic [15:0]  m_err;
    logic [W-1:0] mq[$];
    int           nx_owner, nx_taken, nx_next;
    logic [15:0]  nx_err;
    logic         p_clr, p_rd;
    int           p_src;
    logic [W-1:0] p_wd, p_dummy;

    logic         e_gv, e_wr;
    logic [1:0]   e_gid;
    logic [W-1:0] e_wd, e_rdata;
    logic [N-1:0] e_rdy;
    logic [15:0]  e_err;
    logic [39:0]  ev, ov;
    logic         o_gv, o_wr;
    logic [1:0]   o_gid;
    logic [N-1:0] o_rdy;

    task automatic load(input int n, input int k);
        for (int i = 0; i < k; i++) begin
            pbuf[n][ptail[n]] = {2'(n), 6'($urandom)};
            ptail[n]++;
        end
    endtask

    task automatic drive_inputs();
        rst_i      = c_rst;
        force_full = c_full;
        force_err  = c_err;
        for (int n = 0; n < N; n++) begin
            req_valid_i[n]       = en[n] && (phead[n] < ptail[n]);
            req_data_i[n*W +: W] = (phead[n] < ptail[n]) ? pbuf[n][phead[n]] : W'($urandom);
        end
        rd_en = !c_rst && (mq.size() > 0);
    endtask

    task automatic apply();
        if (p_clr) begin
            mq.delete();
        end else begin
            if (p_rd) p_dummy = mq.pop_front();
            if (p_src >= 0) begin
                mq.push_back(p_wd);
                phead[p_src]++;
            end
        end
        m_owner = nx_owner;
        m_taken = nx_taken;
        m_next  = nx_next;
        m_err   = nx_err;
        p_clr   = 1'b0;
        p_rd    = 1'b0;
        p_src   = -1;
    endtask

    task automatic predict();
        int pick;
        e_gv = 1'b0; e_gid = 2'd0; e_wr = 1'b0; e_wd = '0; e_rdy = '0; e_err = 16'd0;
        nx_owner = m_owner; nx_taken = m_taken; nx_next = m_next; nx_err = m_err;
        p_rd  = rd_en;
        p_src = -1;
        p_clr = 1'b0;
        e_rdata = (mq.size() > 0) ? mq[0] : '0;
        if (rst_i) begin
            p_clr = 1'b1; p_rd = 1'b0;
            nx_owner = -1; nx_taken = 0; nx_next = 0; nx_err = 16'd0;
        end else begin
            e_err = m_err;
            if (force_err && m_err != 16'hFFFF) nx_err = m_err + 16'd1;
            if (m_owner < 0) begin
                pick = -1;
                for (int k = N-1; k >= 0; k--) begin
                    if (req_valid_i[(m_next + k) % N]) pick = (m_next + k) % N;
                end
                if (pick >= 0) begin
                    nx_owner = pick;
                    nx_taken = 0;
                end
            end else begin
                e_gv  = 1'b1;
                e_gid = 2'(m_owner);
                if (req_valid_i[m_owner] && !(force_full || mq.size() >= DEPTH)) begin
                    e_wr = 1'b1;
                    e_wd = pbuf[m_owner][phead[m_owner]];
                    e_rdy[m_owner] = 1'b1;
                    p_src = m_owner;
                    p_wd  = e_wd;
                    nx_taken = m_taken + 1;
                end
                if (!req_valid_i[m_owner] || nx_taken == MB) begin
                    nx_owner = -1;
                    nx_next  = (m_owner + 1) % N;
                end
            end
        end
        ev = {e_gv, e_gid, e_wr, e_wd, e_rdy, e_err, rd_en ? e_rdata : 8'h00};
    endtask

    task automatic sample();
        o_gv  = grant_valid_o;
        o_wr  = fifo_wr_en_o;
        o_gid = grant_id_o;
        o_rdy = req_ready_o;
        ov = {grant_valid_o, (rst_i || e_gv) ? grant_id_o : 2'b00, fifo_wr_en_o, fifo_wdata_o,
              req_ready_o, wr_err_cnt_o, rd_en ? rdata : 8'h00};
    endtask

    task automatic tick();
        @(posedge clk_i);
        apply();
        #1;
        drive_inputs();
        @(negedge clk_i);
        predict();
        sample();
    endtask

    // One reset cycle, then fresh empty producer queues.
    task automatic begin_test();
        c_rst = 1'b1; en = '0; c_full = 1'b0; c_err = 1'b0;
        tick();
        for (int n = 0; n < N; n++) begin
            phead[n] = 0;
            ptail[n] = 0;
        end
        c_rst = 1'b0;
    endtask

    task automatic test_reset();
        c_rst = 1'b1; en = '1; c_full = 1'b0; c_err = 1'b1;
        for (int n = 0; n < N; n++) load(n, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ov !== ev) begin bad++; $display("FAIL reset cyc%0d: got %h want %h", i, ov, ev); end
            total++;
            if ({o_gv, o_wr, o_gid, o_rdy, wr_err_cnt_o} !== 25'd0) begin
                bad++; $display("FAIL reset_zero cyc%0d: got %h want 0", i, {o_gv, o_wr, o_gid, o_rdy, wr_err_cnt_o});
            end
        end
    endtask

    task automatic test_single_req();
        logic [9:0] hist;
        begin_test();
        load(0, 6);
        en = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            hist[i] = o_wr;
            total++;
            if (ov !== ev) begin bad++; $display("FAIL single cyc%0d: got %h want %h", i, ov, ev); end
        end
        total++;
        if (hist !== 10'b0011011110) begin bad++; $display("FAIL single_pattern: got %b want %b", hist, 10'b0011011110); end
    endtask

    task automatic test_all_valid();
        logic [24:0] hist, hexp;
        logic [9:0]  gseq;
        int          ng;
        logic        prev_gv;
        begin_test();
        for (int n = 0; n < N; n++) load(n, 8);
        en = 4'b1111;
        ng = 0; prev_gv = 1'b0; gseq = '0;
        for (int i = 0; i < 25; i++) begin
            tick();
            hist[i] = o_wr;
            hexp[i] = (i % 5) != 0;
            if (o_gv && !prev_gv && ng < 5) begin
                gseq[ng*2 +: 2] = o_gid;
                ng++;
            end
            prev_gv = o_gv;
            total++;
            if (ov !== ev) begin bad++; $display("FAIL all_valid cyc%0d: got %h want %h", i, ov, ev); end
        end
        total++;
        if (hist !== hexp) begin bad++; $display("FAIL all_valid_pattern: got %b want %b", hist, hexp); end
        total++;
        if (ng !== 5 || gseq !== 10'b00_11_10_01_00) begin
            bad++; $display("FAIL grant_order: got n=%0d seq=%b want n=5 seq=%b", ng, gseq, 10'b0011100100);
        end
    endtask

    task automatic test_full_stall();
        logic [8:0] hist, ghist;
        begin_test();
        load(0, 4);
        en = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            c_full = (i >= 3 && i <= 5);
            tick();
            hist[i]  = o_wr;
            ghist[i] = o_gv;
            total++;
            if (ov !== ev) begin bad++; $display("FAIL full_stall cyc%0d: got %h want %h", i, ov, ev); end
        end
        c_full = 1'b0;
        total++;
        if (hist !== 9'b011000110) begin bad++; $display("FAIL stall_wr: got %b want %b", hist, 9'b011000110); end
        total++;
        if (ghist !== 9'b011111110) begin bad++; $display("FAIL stall_grant: got %b want %b", ghist, 9'b011111110); end
    endtask

    task automatic test_valid_drop();
        logic [5:0] gseq;
        int         ng;
        logic       prev_gv;
        begin_test();
        load(2, 4); load(3, 2); load(0, 2);
        ng = 0; prev_gv = 1'b0; gseq = '0;
        for (int i = 0; i < 10; i++) begin
            en = (i == 0) ? 4'b0100 : (i == 1) ? 4'b1101 : 4'b1001;
            tick();
            if (o_gv && !prev_gv && ng < 3) begin
                gseq[ng*2 +: 2] = o_gid;
                ng++;
            end
            prev_gv = o_gv;
            if (i == 2) begin
                total++;
                if ({o_gv, o_gid, o_wr} !== 4'b1100) begin
                    bad++; $display("FAIL drop_exit: got gv/gid/wr=%b want 1100", {o_gv, o_gid, o_wr});
                end
            end
            total++;
            if (ov !== ev) begin bad++; $display("FAIL drop cyc%0d: got %h want %h", i, ov, ev); end
        end
        total++;
        if (ng !== 3 || gseq !== 6'b00_11_10) begin
            bad++; $display("FAIL drop_order: got n=%0d seq=%b want n=3 seq=001110", ng, gseq);
        end
    endtask

    task automatic test_reset_mid_burst();
        begin_test();
        load(1, 6); load(0, 4);
        for (int i = 0; i < 6; i++) begin
            c_rst = (i == 2);
            en    = (i < 3) ? 4'b0010 : 4'b0011;
            tick();
            total++;
            if (ov !== ev) begin bad++; $display("FAIL rst_mid cyc%0d: got %h want %h", i, ov, ev); end
            if (i == 1) begin
                total++;
                if ({o_gv, o_gid, o_wr} !== 4'b1011) begin
                    bad++; $display("FAIL rst_mid_pre: got %b want 1011", {o_gv, o_gid, o_wr});
                end
            end
            if (i == 2 || i == 3) begin
                total++;
                if ({o_gv, o_wr, o_rdy, fifo_wdata_o} !== 14'd0) begin
                    bad++; $display("FAIL rst_mid_idle cyc%0d: got %h want 0", i, {o_gv, o_wr, o_rdy, fifo_wdata_o});
                end
            end
            if (i == 4) begin
                total++;
                if ({o_gv, o_gid} !== 3'b100) begin
                    bad++; $display("FAIL rst_mid_regrant: got %b want 100", {o_gv, o_gid});
                end
            end
        end
        c_rst = 1'b0;
    endtask

    task automatic test_random();
        begin_test();
        for (int n = 0; n < N; n++) load(n, 30);
        for (int i = 0; i < 300; i++) begin
            for (int n = 0; n < N; n++) en[n] = ($urandom_range(0, 9) != 0);
            c_full = ($urandom_range(0, 7) == 0);
            c_err  = ($urandom_range(0, 3) == 0);
            tick();
            total++;
            if (ov !== ev) begin bad++; $display("FAIL random cyc%0d: got %h want %h", i, ov, ev); end
        end
        c_full = 1'b0;
        c_err  = 1'b0;
    endtask

    task automatic test_err_saturate();
        begin_test();
        c_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ov !== ev) begin bad++; $display("FAIL err cyc%0d: got %h want %h", i, ov, ev); end
        end
        c_err = 1'b0;
        tick();
        total++;
        if (wr_err_cnt_o !== 16'd3) begin bad++; $display("FAIL err_three: got %0d want 3", wr_err_cnt_o); end
        c_err = 1'b1;
        repeat (65531) tick();
        c_err = 1'b0;
        tick();
        total++;
        if (wr_err_cnt_o !== 16'hFFFE) begin bad++; $display("FAIL err_fffe: got %h want fffe", wr_err_cnt_o); end
        for (int i = 0; i < 3; i++) begin
            c_err = 1'b1;
            tick();
            c_err = 1'b0;
            tick();
            total++;
            if (ov !== ev) begin bad++; $display("FAIL err_sat cyc%0d: got %h want %h", i, ov, ev); end
        end
        total++;
        if (wr_err_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL err_ffff: got %h want ffff", wr_err_cnt_o); end
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = '0; req_data_i = '0; rd_en = 1'b0;
        force_full = 1'b0; force_err = 1'b0;
        c_rst = 1'b1; c_full = 1'b0; c_err = 1'b0; en = '0;
        for (int n = 0; n < N; n++) begin
            phead[n] = 0;
            ptail[n] = 0;
        end
        m_owner = -1; m_taken = 0; m_next = 0; m_err = 16'd0;
        nx_owner = -1; nx_taken = 0; nx_next = 0; nx_err = 16'd0;
        p_clr = 1'b0; p_rd = 1'b0; p_src = -1; p_wd = '0;

        test_reset();
        test_single_req();
        test_all_valid();
        test_full_stall();
        test_valid_drop();
        test_reset_mid_burst();
        test_random();
        test_err_saturate();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
